// File: rtl/match_cmd_pkg.sv
// Shared constants, enums and helpers for the match-style ALU command issuer.
// Reserved selector codes are the ALU opcodes; any other A value multiplies.
package match_cmd_pkg;

    localparam int OP_INC = 17;
    localparam int OP_ADD = 21;
    localparam int OP_SUB = 34;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        KIND_INC = 2'd0,
        KIND_ADD = 2'd1,
        KIND_SUB = 2'd2,
        KIND_MUL = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // True when a value collides with one of the ALU opcode selectors
    function automatic logic is_reserved_code(input logic [31:0] value);
        return (value == 32'(OP_INC)) ||
               (value == 32'(OP_ADD)) ||
               (value == 32'(OP_SUB));
    endfunction

endpackage

// File: rtl/match_cmd_encoder.sv
// Maps an abstract op request onto the ALU selector/operand pair.
// A MUL whose X operand aliases an opcode cannot be expressed and is flagged.
module match_cmd_encoder
    import match_cmd_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  kind_e              kind,
    input  logic [NBITS-1:0]   x,
    input  logic [NBITS-1:0]   y,
    output logic [NBITS-1:0]   a,
    output logic [NBITS-1:0]   b,
    output logic               illegal
);

    // Selector encoding; B always carries Y
    always_comb begin
        a       = x;
        b       = y;
        illegal = 1'b0;
        unique case (kind)
            KIND_INC: a = NBITS'(OP_INC);
            KIND_ADD: a = NBITS'(OP_ADD);
            KIND_SUB: a = NBITS'(OP_SUB);
            KIND_MUL: illegal = is_reserved_code(32'(x));
        endcase
    end

endmodule

// File: rtl/match_cmd_issuer.sv
// Request/response front end for the match-style selector ALU.
// Optional result checker enabled by MATCH_CMD_ISSUER_CHECK_EN.
module match_cmd_issuer
    import match_cmd_pkg::*;
#(
    parameter int NBITS       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_KIND,
    input  logic [NBITS-1:0] REQ_X,
    input  logic [NBITS-1:0] REQ_Y,
    output logic [NBITS-1:0] A,
    output logic [NBITS-1:0] B,
    input  logic [NBITS-1:0] XOUT,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [NBITS-1:0] RSP_DATA,
    output logic             RSP_ERR
`ifdef MATCH_CMD_ISSUER_CHECK_EN
    ,
    output logic             RSP_MISMATCH
`endif
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [NBITS-1:0]   enc_a;
    logic [NBITS-1:0]   enc_b;
    logic               enc_illegal;

    match_cmd_encoder #(
        .NBITS   (NBITS)
    ) u_enc (
        .kind    (kind_e'(REQ_KIND)),
        .x       (REQ_X),
        .y       (REQ_Y),
        .a       (enc_a),
        .b       (enc_b),
        .illegal (enc_illegal)
    );

    assign REQ_READY = (state == ST_IDLE) && !RST;
    assign RSP_VALID = (state == ST_RESP);

`ifdef MATCH_CMD_ISSUER_CHECK_EN
    logic [NBITS-1:0] exp_x;

    // Reference ALU evaluated on the held A/B pair
    always_comb begin
        exp_x = A * B;
        if (A == NBITS'(OP_INC))
            exp_x = A + 1'b1;
        else if (A == NBITS'(OP_ADD))
            exp_x = A + B;
        else if (A == NBITS'(OP_SUB))
            exp_x = A - B;
    end
`endif

    // Issue FSM: encode, hold A/B for the settle window, capture, respond
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            A        <= '0;
            B        <= '0;
            RSP_DATA <= '0;
            RSP_ERR  <= 1'b0;
`ifdef MATCH_CMD_ISSUER_CHECK_EN
            RSP_MISMATCH <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        if (enc_illegal) begin
                            RSP_DATA <= '0;
                            RSP_ERR  <= 1'b1;
`ifdef MATCH_CMD_ISSUER_CHECK_EN
                            RSP_MISMATCH <= 1'b0;
`endif
                            state    <= ST_RESP;
                        end else begin
                            A     <= enc_a;
                            B     <= enc_b;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        RSP_DATA <= XOUT;
                        RSP_ERR  <= 1'b0;
`ifdef MATCH_CMD_ISSUER_CHECK_EN
                        RSP_MISMATCH <= (XOUT != exp_x);
`endif
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_cmd_issuer.sv
// Directed bench for match_cmd_issuer: one instance at WAIT_CYCLES=1 driven
// by a behavioural ALU, one at WAIT_CYCLES=3 with a hand-driven XOUT.
module tb_match_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Instance 1 (WAIT_CYCLES=1)
    logic       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0] req_kind;
    logic [7:0] req_x, req_y, a, b, xout, rsp_data;
    logic       corrupt;
    logic       mism;

    // Instance 2 (WAIT_CYCLES=3)
    logic       req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [7:0] a3, b3, xout3, rsp_data3;
    logic       mism3;

    match_cmd_issuer #(.NBITS(8), .WAIT_CYCLES(1)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_KIND(req_kind), .REQ_X(req_x), .REQ_Y(req_y),
        .A(a), .B(b), .XOUT(xout),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA(rsp_data), .RSP_ERR(rsp_err)
`ifdef MATCH_CMD_ISSUER_CHECK_EN
        , .RSP_MISMATCH(mism)
`endif
    );

    match_cmd_issuer #(.NBITS(8), .WAIT_CYCLES(3)) dut3 (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
        .REQ_KIND(req_kind), .REQ_X(req_x), .REQ_Y(req_y),
        .A(a3), .B(b3), .XOUT(xout3),
        .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready3),
        .RSP_DATA(rsp_data3), .RSP_ERR(rsp_err3)
`ifdef MATCH_CMD_ISSUER_CHECK_EN
        , .RSP_MISMATCH(mism3)
`endif
    );

`ifndef MATCH_CMD_ISSUER_CHECK_EN
    assign mism  = 1'b0;
    assign mism3 = 1'b0;
`endif

    // Behavioural ALU for instance 1, with optional result corruption
    always_comb begin
        logic [7:0] r;
        case (a)
            8'd17:   r = 8'd18;
            8'd21:   r = 8'd21 + b;
            8'd34:   r = 8'd34 - b;
            default: r = a * b;
        endcase
        xout = corrupt ? (r ^ 8'h01) : r;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on instance 1, wait for the response, optionally stall it
    task automatic run_op(input string tag, input logic [1:0] kind,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input logic [7:0] edata, input logic eerr,
                          input int elat, input int stall,
                          input logic emism);
        int n;
        req_kind  = kind;
        req_x     = x;
        req_y     = y;
        req_valid = 1'b1;
        chk({tag, "_rdy"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        chk({tag, "_a"}, a, ea);
        chk({tag, "_b"}, b, eb);
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_data"}, rsp_data, edata);
        chk({tag, "_err"}, rsp_err, eerr);
`ifdef MATCH_CMD_ISSUER_CHECK_EN
        chk({tag, "_mism"}, mism, emism);
`endif
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_v"}, rsp_valid, 1);
            chk({tag, "_hold_d"}, rsp_data, edata);
            chk({tag, "_hold_e"}, rsp_err, eerr);
            chk({tag, "_hold_rdy"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_drop_v"}, rsp_valid, 0);
        chk({tag, "_idle_rdy"}, req_ready, 1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_valid3 = 1'b0;
        rsp_ready  = 1'b0;
        rsp_ready3 = 1'b0;
        req_kind   = 2'd0;
        req_x      = 8'd0;
        req_y      = 8'd0;
        xout3      = 8'd0;
        corrupt    = 1'b0;
        step();
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_v", rsp_valid, 0);
        chk("rst_d", rsp_data, 0);
        chk("rst_e", rsp_err, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_mism", mism, 0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", req_ready, 1);

        run_op("inc", 2'd0, 8'd0, 8'd0, 8'd17, 8'd0, 8'd18, 0, 2, 0, 0);
        run_op("add", 2'd1, 8'd0, 8'd5, 8'd21, 8'd5, 8'd26, 0, 2, 0, 0);
        run_op("sub", 2'd2, 8'd0, 8'd40, 8'd34, 8'd40, 8'd250, 0, 2, 0, 0);
        run_op("mul", 2'd3, 8'd3, 8'd100, 8'd3, 8'd100, 8'd44, 0, 2, 0, 0);
        run_op("mul_bad", 2'd3, 8'd21, 8'd2, 8'd3, 8'd100, 8'd0, 1, 1, 0, 0);
        run_op("bp", 2'd1, 8'd0, 8'd7, 8'd21, 8'd7, 8'd28, 0, 2, 3, 0);

        // Reset while the op is settling drops it entirely
        req_kind  = 2'd1;
        req_y     = 8'd9;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_v", rsp_valid, 0);
        chk("abort_a", a, 0);
        chk("abort_b", b, 0);
        chk("abort_d", rsp_data, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_quiet", rsp_valid, 0);
        end
        chk("abort_rdy", req_ready, 1);
        run_op("add1", 2'd1, 8'd0, 8'd1, 8'd21, 8'd1, 8'd22, 0, 2, 0, 0);

`ifdef MATCH_CMD_ISSUER_CHECK_EN
        corrupt = 1'b1;
        run_op("corrupt", 2'd1, 8'd0, 8'd1, 8'd21, 8'd1, 8'd23, 0, 2, 0, 1);
        corrupt = 1'b0;
`endif

        // WAIT_CYCLES=3: value present at edge t+3 is the one captured
        req_kind   = 2'd1;
        req_y      = 8'd9;
        req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        chk("w3_a", a3, 21);
        chk("w3_b", b3, 9);
        xout3 = 8'h55;
        step();
        chk("w3_v1", rsp_valid3, 0);
        step();
        chk("w3_v2", rsp_valid3, 0);
        xout3 = 8'hAA;
        step();
        chk("w3_v3", rsp_valid3, 1);
        chk("w3_d", rsp_data3, 8'hAA);
        chk("w3_e", rsp_err3, 0);
`ifdef MATCH_CMD_ISSUER_CHECK_EN
        chk("w3_mism", mism3, 1);
`endif
        xout3 = 8'h11;
        step();
        chk("w3_hold", rsp_data3, 8'hAA);
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;
        chk("w3_drop", rsp_valid3, 0);
        chk("w3_rdy", req_ready3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
